int_ctrl_nest: RTL

- Parametrised interrupt controller; successor to the single-request `int_ask`/`int_num` path into the CPU core.
- Gathers CHANNELS interrupt lines, each with its own mask, edge/level mode and priority.
- Arbitrates the lines and presents one vector to the core's `int_ask`/`int_num` inputs.
- Tracks nested in-service interrupts on a stack, so a higher-priority line can pre-empt a lower one.

---
 rtl/int_ctrl_nest_pkg.sv | 25 ++
 rtl/int_ctrl_nest_prio_arb.sv | 40 ++++
 rtl/int_ctrl_nest.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_nest_pkg.sv
// Shared definitions for the nested interrupt controller: register map,
// controller states and STATUS field layout.
package int_ctrl_nest_pkg;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_EDGE    = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_PRIO    = 3'd3;
    localparam logic [2:0] REG_BASE    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned DEPTH_W = 4;

    localparam int unsigned STAT_CUR_LSB   = 0;
    localparam int unsigned STAT_DEPTH_LSB = 4;
    localparam int unsigned STAT_ASK_BIT   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

endpackage

// File: rtl/int_ctrl_nest_prio_arb.sv
// Combinational priority arbiter: highest priority at or above the threshold
// wins, ties resolved towards the lowest channel index.
module int_prio_arb
    import int_ctrl_nest_pkg::*;
#(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned PRIO_BITS = 2
) (
    input  logic [CHANNELS-1:0]           i_elig,
    input  logic [CHANNELS*PRIO_BITS-1:0] i_prio,
    input  logic [PRIO_BITS:0]            i_thresh,
    output logic [IDX_W-1:0]              o_idx,
    output logic                          o_valid
);

    logic                 w_found;
    logic [PRIO_BITS-1:0] w_best;
    logic [PRIO_BITS-1:0] w_p;
    logic [IDX_W-1:0]     w_idx;

    // i_thresh is (top-of-stack priority + 1), or 0 with an empty stack
    always_comb begin
        w_found = 1'b0;
        w_best  = '0;
        w_p     = '0;
        w_idx   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_p = i_prio[c*PRIO_BITS +: PRIO_BITS];
            if (i_elig[c] && ({1'b0, w_p} >= i_thresh) && (!w_found || (w_p > w_best))) begin
                w_found = 1'b1;
                w_best  = w_p;
                w_idx   = IDX_W'(c);
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = w_found;

endmodule

// File: rtl/int_ctrl_nest.sv
// Nested interrupt controller: per-channel mask/mode/priority, one vector
// request towards the core, and an in-service stack for pre-emption.
module int_ctrl_nest
    import int_ctrl_nest_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned PRIO_BITS  = 2,
    parameter int unsigned NEST_DEPTH = 4,
    parameter int unsigned VEC_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] irq,
    output logic                int_ask,
    output logic [VEC_W-1:0]    int_num,
    input  logic                int_ack,
    input  logic                int_eoi,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata
);

    localparam int unsigned PW = CHANNELS * PRIO_BITS;

    state_t               r_state, w_state_nxt;
    logic [CHANNELS-1:0]  r_enable, r_edge, r_pending, r_irq_prev;
    logic [PW-1:0]        r_prio;
    logic [VEC_W-1:0]     r_base, r_num;
    logic [IDX_W-1:0]     r_chan;
    logic [IDX_W-1:0]     r_stack [NEST_DEPTH];
    logic [DEPTH_W-1:0]   r_depth;

    logic [CHANNELS-1:0]  w_onstack, w_elig, w_ack_clr, w_w1c, w_pend_nxt;
    logic [IDX_W-1:0]     w_top_chan, w_win_idx;
    logic [PRIO_BITS-1:0] w_top_prio;
    logic [PRIO_BITS:0]   w_thresh;
    logic                 w_win_valid, w_room, w_push, w_pop, w_latch;
    logic [31:0]          w_status;
    logic                 w_unused;

    // Only entries below the depth pointer are live; popped slots are stale
    always_comb begin
        w_top_chan = '0;
        w_onstack  = '0;
        for (int unsigned s = 0; s < NEST_DEPTH; s++) begin
            if (s < 32'(r_depth)) begin
                if (s + 1 == 32'(r_depth)) w_top_chan = r_stack[s];
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (r_stack[s] == IDX_W'(c)) w_onstack[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_top_prio = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (w_top_chan == IDX_W'(c)) w_top_prio = r_prio[c*PRIO_BITS +: PRIO_BITS];
        end
    end

    assign w_thresh = (r_depth == '0) ? '0 : ({1'b0, w_top_prio} + (PRIO_BITS+1)'(1));
    assign w_elig   = r_pending & r_enable & ~w_onstack;
    assign w_room   = 32'(r_depth) < NEST_DEPTH;

    int_prio_arb #(
        .CHANNELS  (CHANNELS),
        .PRIO_BITS (PRIO_BITS)
    ) u_arb (
        .i_elig   (w_elig),
        .i_prio   (r_prio),
        .i_thresh (w_thresh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid && w_room) begin
                    w_state_nxt = REQ;
                    w_latch     = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                // An eoi retires the top level before any new arbitration
                if (int_eoi) begin
                    w_pop = 1'b1;
                    if (r_depth == DEPTH_W'(1)) w_state_nxt = IDLE;
                end else if (w_win_valid && w_room) begin
                    w_state_nxt = REQ;
                    w_latch     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    assign int_ask = (r_state == REQ);
    assign int_num = r_num;

    always_comb begin
        w_ack_clr = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_ack_clr[c] = w_push && (r_chan == IDX_W'(c));
        end
    end

    assign w_w1c = (cfg_we && (cfg_addr == REG_PENDING)) ? cfg_wdata[CHANNELS-1:0] : '0;
    // Edge channels: a fresh rising edge beats any clear in the same cycle
    assign w_pend_nxt = (~r_edge & irq)
                      | (r_edge & ((irq & ~r_irq_prev) | (r_pending & ~(w_ack_clr | w_w1c))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= '0;
            r_edge     <= '0;
            r_pending  <= '0;
            r_irq_prev <= '0;
            r_prio     <= '0;
            r_base     <= '0;
            r_num      <= '0;
            r_chan     <= '0;
            r_depth    <= '0;
            for (int unsigned s = 0; s < NEST_DEPTH; s++) r_stack[s] <= '0;
        end else begin
            r_irq_prev <= irq;
            r_pending  <= w_pend_nxt;
            if (cfg_we) begin
                case (cfg_addr)
                    REG_ENABLE: r_enable <= cfg_wdata[CHANNELS-1:0];
                    REG_EDGE:   r_edge   <= cfg_wdata[CHANNELS-1:0];
                    REG_PRIO:   r_prio   <= cfg_wdata[PW-1:0];
                    REG_BASE:   r_base   <= cfg_wdata[VEC_W-1:0];
                    default: ;
                endcase
            end
            if (w_latch) begin
                r_chan <= w_win_idx;
                r_num  <= r_base + VEC_W'(w_win_idx);
            end
            if (w_push) begin
                for (int unsigned s = 0; s < NEST_DEPTH; s++) begin
                    if (32'(r_depth) == s) r_stack[s] <= r_chan;
                end
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_CUR_LSB +: IDX_W]     = w_top_chan;
        w_status[STAT_DEPTH_LSB +: DEPTH_W] = r_depth;
        w_status[STAT_ASK_BIT]              = int_ask;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_ENABLE:  cfg_rdata[CHANNELS-1:0] = r_enable;
            REG_EDGE:    cfg_rdata[CHANNELS-1:0] = r_edge;
            REG_PENDING: cfg_rdata[CHANNELS-1:0] = r_pending;
            REG_PRIO:    cfg_rdata[PW-1:0]       = r_prio;
            REG_BASE:    cfg_rdata[VEC_W-1:0]    = r_base;
            REG_STATUS:  cfg_rdata               = w_status;
            default: ;
        endcase
    end

    assign w_unused = ^cfg_wdata;

endmodule
